// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready stream bundle carrying a CTRL/DATA payload between pipeline stages.
// The master drives valid/ctrl/data; the slave drives ready.
interface pipe_stage_skid_reg_if #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 128
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and optional 2-entry skid.
// CTRL is zeroed whenever a slot holds no live beat; DATA is only cleared by reset.
module pipe_stage_skid_reg #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 128,
  parameter bit          SKID   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_skid_reg_if.slave  up,
  pipe_stage_skid_reg_if.master dn,
  output logic [1:0]            occ
);

  logic              r_rdy;
  logic              r_main_v;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_v;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_emit;
  logic              w_rdy_nx;
  logic              w_main_v_nx;
  logic [CTRL_W-1:0] w_main_ctrl_nx;
  logic [DATA_W-1:0] w_main_data_nx;
  logic              w_skid_v_nx;
  logic [CTRL_W-1:0] w_skid_ctrl_nx;
  logic [DATA_W-1:0] w_skid_data_nx;

  // r_rdy stays low through reset so nothing is accepted until the first clean edge.
  if (SKID) begin : g_skid
    assign w_in_ready = r_rdy;
  end else begin : g_single
    assign w_in_ready = r_rdy & (~r_main_v | dn.ready);
  end

  assign w_accept = up.valid & w_in_ready;
  assign w_emit   = r_main_v & dn.ready;

  always_comb begin
    w_main_v_nx    = r_main_v;
    w_main_ctrl_nx = r_main_ctrl;
    w_main_data_nx = r_main_data;
    w_skid_v_nx    = r_skid_v;
    w_skid_ctrl_nx = r_skid_ctrl;
    w_skid_data_nx = r_skid_data;
    if (flush) begin
      w_main_v_nx    = 1'b0;
      w_main_ctrl_nx = '0;
      w_skid_v_nx    = 1'b0;
      w_skid_ctrl_nx = '0;
    end else if (r_skid_v) begin
      if (w_emit) begin
        w_main_v_nx    = 1'b1;
        w_main_ctrl_nx = r_skid_ctrl;
        w_main_data_nx = r_skid_data;
        w_skid_v_nx    = 1'b0;
        w_skid_ctrl_nx = '0;
      end
    end else if (w_emit || !r_main_v) begin
      if (w_accept) begin
        w_main_v_nx    = 1'b1;
        w_main_ctrl_nx = up.ctrl;
        w_main_data_nx = up.data;
      end else if (w_emit) begin
        w_main_v_nx    = 1'b0;
        w_main_ctrl_nx = '0;
      end
    end else if (w_accept && SKID) begin
      // MAIN is stalled, so the beat parks behind it to keep FIFO order.
      w_skid_v_nx    = 1'b1;
      w_skid_ctrl_nx = up.ctrl;
      w_skid_data_nx = up.data;
    end
    w_rdy_nx = SKID ? ~w_skid_v_nx : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy       <= 1'b0;
      r_main_v    <= 1'b0;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_v    <= 1'b0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_rdy       <= w_rdy_nx;
      r_main_v    <= w_main_v_nx;
      r_main_ctrl <= w_main_ctrl_nx;
      r_main_data <= w_main_data_nx;
      r_skid_v    <= w_skid_v_nx;
      r_skid_ctrl <= w_skid_ctrl_nx;
      r_skid_data <= w_skid_data_nx;
    end
  end

  assign up.ready = w_in_ready;
  assign dn.valid = r_main_v;
  assign dn.ctrl  = r_main_ctrl;
  assign dn.data  = r_main_data;
  assign occ      = {1'b0, r_main_v} + {1'b0, r_skid_v};

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: DUT0 uses SKID=1, DUT1 uses SKID=0, both checked against a FIFO model.
module tb_pipe_stage_skid_reg;
  localparam int unsigned CW = 8;
  localparam int unsigned DW = 128;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int unsigned   k;
    bit            iv;
    logic [CW-1:0] ic;
    logic [DW-1:0] id;
    bit            ordy;
    bit            fl;
    bit            e_rdy;
    bit            e_ov;
    logic [1:0]    e_occ;
    logic [CW-1:0] e_oc;
    logic [DW-1:0] e_od;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       fl0, fl1;
  logic [1:0] occ0, occ1;

  always #5 clk = ~clk;

  pipe_stage_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up0 ();
  pipe_stage_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn0 ();
  pipe_stage_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up1 ();
  pipe_stage_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn1 ();

  pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .flush(fl0), .up(up0.slave), .dn(dn0.master), .occ(occ0));
  pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .flush(fl1), .up(up1.slave), .dn(dn1.master), .occ(occ1));

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  beat_t q0[$];
  beat_t q1[$];
  bit    live[2];
  bit    d_v[2], d_ordy[2], d_fl[2], acc[2], emi[2];
  beat_t d_b[2];
  vec_t  tv[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int unsigned k, input bit iv, input logic [CW-1:0] ic,
                       input logic [DW-1:0] id, input bit ordy, input bit fl);
    d_v[k] = iv; d_ordy[k] = ordy; d_fl[k] = fl;
    d_b[k].ctrl = ic; d_b[k].data = id;
    if (k == 0) begin
      up0.valid = iv; up0.ctrl = ic; up0.data = id; dn0.ready = ordy; fl0 = fl;
    end else begin
      up1.valid = iv; up1.ctrl = ic; up1.data = id; dn1.ready = ordy; fl1 = fl;
    end
  endtask

  task automatic get_obs(input int unsigned k, output logic rdy, output logic ov,
                         output logic [CW-1:0] oc, output logic [DW-1:0] od, output logic [1:0] oo);
    if (k == 0) begin
      rdy = up0.ready; ov = dn0.valid; oc = dn0.ctrl; od = dn0.data; oo = occ0;
    end else begin
      rdy = up1.ready; ov = dn1.valid; oc = dn1.ctrl; od = dn1.data; oo = occ1;
    end
  endtask

  task automatic reset_check(input int unsigned k);
    logic rdy, ov; logic [CW-1:0] oc; logic [DW-1:0] od; logic [1:0] oo;
    get_obs(k, rdy, ov, oc, od, oo);
    chk($sformatf("dut%0d rst in_ready", k), rdy, 0);
    chk($sformatf("dut%0d rst out_valid", k), ov, 0);
    chk($sformatf("dut%0d rst out_ctrl", k), oc, 0);
    chk($sformatf("dut%0d rst out_data", k), od, 0);
    chk($sformatf("dut%0d rst occ", k), oo, 0);
  endtask

  task automatic model_check(input int unsigned k);
    logic rdy, ov; logic [CW-1:0] oc; logic [DW-1:0] od; logic [1:0] oo;
    beat_t h; int unsigned sz; bit ev, er;
    h = '0;
    if (k == 0) begin sz = q0.size(); if (sz != 0) h = q0[0]; end
    else        begin sz = q1.size(); if (sz != 0) h = q1[0]; end
    ev = (sz != 0);
    er = live[k] && ((k == 0) ? (sz < 2) : (sz == 0 || d_ordy[k]));
    get_obs(k, rdy, ov, oc, od, oo);
    chk($sformatf("dut%0d in_ready", k), rdy, er);
    chk($sformatf("dut%0d out_valid", k), ov, ev);
    chk($sformatf("dut%0d occ", k), oo, sz);
    chk($sformatf("dut%0d out_ctrl", k), oc, ev ? h.ctrl : '0);
    if (ev) chk($sformatf("dut%0d out_data", k), od, h.data);
    acc[k] = d_v[k] && er && !d_fl[k];
    emi[k] = ev && d_ordy[k];
  endtask

  task automatic model_update(input int unsigned k);
    if (k == 0) begin
      if (d_fl[k]) q0.delete();
      else begin
        if (emi[k]) void'(q0.pop_front());
        if (acc[k]) q0.push_back(d_b[k]);
      end
    end else begin
      if (d_fl[k]) q1.delete();
      else begin
        if (emi[k]) void'(q1.pop_front());
        if (acc[k]) q1.push_back(d_b[k]);
      end
    end
    live[k] = 1'b1;
  endtask

  task automatic step();
    #1;
    for (int unsigned k = 0; k < 2; k++) begin
      if (rst) reset_check(k); else model_check(k);
    end
    @(posedge clk);
    for (int unsigned k = 0; k < 2; k++) begin
      if (rst) begin
        live[k] = 1'b0;
        if (k == 0) q0.delete(); else q1.delete();
      end else model_update(k);
    end
    #2;
  endtask

  function automatic vec_t mk(input int unsigned k, input bit iv, input logic [CW-1:0] ic,
                              input logic [DW-1:0] id, input bit ordy, input bit fl,
                              input bit er, input bit eov, input logic [1:0] eocc,
                              input logic [CW-1:0] eoc, input logic [DW-1:0] eod);
    vec_t v;
    v.k = k; v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_rdy = er; v.e_ov = eov; v.e_occ = eocc; v.e_oc = eoc; v.e_od = eod;
    return v;
  endfunction

  initial begin
    logic rdy, ov; logic [CW-1:0] oc; logic [DW-1:0] od; logic [1:0] oo;
    logic [31:0] seq;

    // Stall/skid, flush at occ=2, flush with in_ready=1 on the SKID=1 instance.
    tv.push_back(mk(0, 1, 8'h01, 'hA0, 0, 0, 1, 0, 0, 8'h00, 'h0));
    tv.push_back(mk(0, 1, 8'h02, 'hB0, 0, 0, 1, 1, 1, 8'h01, 'hA0));
    tv.push_back(mk(0, 1, 8'h03, 'hC0, 0, 0, 0, 1, 2, 8'h01, 'hA0));
    tv.push_back(mk(0, 1, 8'h03, 'hC0, 0, 0, 0, 1, 2, 8'h01, 'hA0));
    tv.push_back(mk(0, 1, 8'h03, 'hC0, 1, 0, 0, 1, 2, 8'h01, 'hA0));
    tv.push_back(mk(0, 1, 8'h03, 'hC0, 1, 0, 1, 1, 1, 8'h02, 'hB0));
    tv.push_back(mk(0, 0, 8'h00, 'h0,  1, 0, 1, 1, 1, 8'h03, 'hC0));
    tv.push_back(mk(0, 0, 8'h00, 'h0,  0, 0, 1, 0, 0, 8'h00, 'h0));
    tv.push_back(mk(0, 1, 8'h04, 'hE0, 0, 0, 1, 0, 0, 8'h00, 'h0));
    tv.push_back(mk(0, 1, 8'h05, 'hF0, 0, 0, 1, 1, 1, 8'h04, 'hE0));
    tv.push_back(mk(0, 1, 8'hFF, 'hD0, 0, 1, 0, 1, 2, 8'h04, 'hE0));
    tv.push_back(mk(0, 0, 8'h00, 'h0,  1, 0, 1, 0, 0, 8'h00, 'h0));
    tv.push_back(mk(0, 1, 8'h06, 'h60, 1, 1, 1, 0, 0, 8'h00, 'h0));
    tv.push_back(mk(0, 0, 8'h00, 'h0,  1, 0, 1, 0, 0, 8'h00, 'h0));
    tv.push_back(mk(0, 1, 8'h07, 'h70, 1, 0, 1, 0, 0, 8'h00, 'h0));
    tv.push_back(mk(0, 0, 8'h00, 'h0,  1, 0, 1, 1, 1, 8'h07, 'h70));
    tv.push_back(mk(0, 0, 8'h00, 'h0,  1, 0, 1, 0, 0, 8'h00, 'h0));
    // Combinational in_ready and flush on the SKID=0 instance.
    tv.push_back(mk(1, 1, 8'h11, 'h11, 0, 0, 1, 0, 0, 8'h00, 'h0));
    tv.push_back(mk(1, 1, 8'h12, 'h12, 0, 0, 0, 1, 1, 8'h11, 'h11));
    tv.push_back(mk(1, 1, 8'h12, 'h12, 1, 0, 1, 1, 1, 8'h11, 'h11));
    tv.push_back(mk(1, 0, 8'h00, 'h0,  1, 0, 1, 1, 1, 8'h12, 'h12));
    tv.push_back(mk(1, 0, 8'h00, 'h0,  0, 0, 1, 0, 0, 8'h00, 'h0));
    tv.push_back(mk(1, 1, 8'h13, 'h13, 0, 0, 1, 0, 0, 8'h00, 'h0));
    tv.push_back(mk(1, 0, 8'h00, 'h0,  0, 1, 0, 1, 1, 8'h13, 'h13));
    tv.push_back(mk(1, 0, 8'h00, 'h0,  0, 0, 1, 0, 0, 8'h00, 'h0));

    rst = 1'b1;
    drive(0, 0, '0, '0, 0, 0);
    drive(1, 0, '0, '0, 0, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // Back-to-back streaming with out_ready held high.
    for (int unsigned i = 0; i < 10; i++) begin
      drive(0, 1, CW'(i + 1), DW'(i), 1, 0);
      drive(1, 1, CW'(i + 1), DW'(i), 1, 0);
      step();
      for (int unsigned k = 0; k < 2; k++) begin
        get_obs(k, rdy, ov, oc, od, oo);
        chk($sformatf("dut%0d stream valid %0d", k, i), ov, 1);
        chk($sformatf("dut%0d stream data %0d", k, i), od, DW'(i));
      end
    end
    drive(0, 0, '0, '0, 1, 0);
    drive(1, 0, '0, '0, 1, 0);
    step();

    // Reset asserted with beats held in both instances.
    drive(0, 1, 8'h55, 'h55, 0, 0);
    drive(1, 1, 8'h55, 'h55, 0, 0);
    step();
    drive(0, 1, 8'h66, 'h66, 0, 0);
    drive(1, 1, 8'h66, 'h66, 0, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 0, '0, '0, 0, 0);
    drive(1, 0, '0, '0, 0, 0);
    step();
    step();

    foreach (tv[i]) begin
      drive(tv[i].k, tv[i].iv, tv[i].ic, tv[i].id, tv[i].ordy, tv[i].fl);
      drive(1 - tv[i].k, 0, '0, '0, 0, 0);
      #1;
      get_obs(tv[i].k, rdy, ov, oc, od, oo);
      chk($sformatf("vec%0d in_ready", i), rdy, tv[i].e_rdy);
      chk($sformatf("vec%0d out_valid", i), ov, tv[i].e_ov);
      chk($sformatf("vec%0d occ", i), oo, tv[i].e_occ);
      chk($sformatf("vec%0d out_ctrl", i), oc, tv[i].e_oc);
      if (tv[i].e_ov) chk($sformatf("vec%0d out_data", i), od, tv[i].e_od);
      step();
    end

    // Random valid/ready/flush traffic on both instances against the FIFO model.
    seq = 32'h1000;
    for (int unsigned c = 0; c < 10000; c++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        seq = seq + 1;
        drive(k, $urandom_range(0, 3) != 0, CW'($urandom), {$urandom, $urandom, $urandom, seq},
              $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
      end
      step();
    end
    drive(0, 0, '0, '0, 1, 0);
    drive(1, 0, '0, '0, 1, 0);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
